// File: rtl/trail_scheduler.sv
// trail_scheduler: player trail particle buffer for the VGA renderer.
// Once per frame tick it ages, drifts and expires every particle (one entry
// per cycle), then shifts the buffer and inserts a new particle at entry 0.
// All arrays are plain registers so the renderer can read them combinationally.
module trail_scheduler #(
    parameter int TRAIL_LEN = 41,
    parameter int LIFE_MAX  = 10,
    parameter int DECAY_DIV = 4,
    parameter int DRIFT     = 2,
    parameter int PLAYER_X  = 160,
    parameter int Y_OFFSET  = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_tick,
    input  logic [1:0]                 gamemode,
    input  logic [8:0]                 player_y,
    output logic [TRAIL_LEN-1:0][9:0]  trail_x,
    output logic [TRAIL_LEN-1:0][8:0]  trail_y,
    output logic [TRAIL_LEN-1:0][3:0]  trail_life,
    output logic                       busy
);

    localparam int                IDX_W      = $clog2(TRAIL_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(TRAIL_LEN - 1);
    localparam logic [3:0]        DECAY_LAST = 4'(DECAY_DIV - 1);
    localparam logic [9:0]        DRIFT_X    = 10'(DRIFT);
    localparam logic [9:0]        NEW_X      = 10'(PLAYER_X);
    localparam logic [8:0]        Y_OFF      = 9'(Y_OFFSET);
    localparam logic [3:0]        NEW_LIFE   = 4'(LIFE_MAX);

    localparam logic [1:0] MODE_START = 2'b00;
    localparam logic [1:0] MODE_PLAY  = 2'b01;
    localparam logic [1:0] MODE_OVER  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AGE   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t               state_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [3:0]           decay_cnt_reg;
    logic                 decay_now_reg;
    logic [1:0]           mode_reg;
    logic [8:0]           py_reg;
    logic                 busy_reg;

    logic [TRAIL_LEN-1:0][9:0] x_reg;
    logic [TRAIL_LEN-1:0][8:0] y_reg;
    logic [TRAIL_LEN-1:0][3:0] life_reg;

    // Start mode wipes everything regardless of state; it outranks ticks.
    logic clear;
    assign clear = (gamemode == MODE_START);

    // New particle y: player centre, wrapping in 9 bits.
    logic [8:0] new_y;
    assign new_y = py_reg + Y_OFF;

    assign trail_x    = x_reg;
    assign trail_y    = y_reg;
    assign trail_life = life_reg;
    assign busy       = busy_reg;

    // Sweep sequencer: latches the frame context on a tick and walks idx.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            busy_reg      <= 1'b0;
            decay_cnt_reg <= '0;
            decay_now_reg <= 1'b0;
            if (rst) begin
                mode_reg <= '0;
                py_reg   <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    // Pause ticks are dropped and leave the decay phase alone.
                    if (frame_tick && (gamemode == MODE_PLAY || gamemode == MODE_OVER)) begin
                        mode_reg      <= gamemode;
                        py_reg        <= player_y;
                        decay_now_reg <= (decay_cnt_reg == DECAY_LAST);
                        decay_cnt_reg <= (decay_cnt_reg == DECAY_LAST) ? 4'd0
                                                                       : decay_cnt_reg + 4'd1;
                        idx_reg       <= '0;
                        state_reg     <= AGE;
                        busy_reg      <= 1'b1;
                    end
                end
                AGE: begin
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= SHIFT;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                SHIFT: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < TRAIL_LEN; gi++) begin : g_entry
            logic age_hit;
            logic shift_hit;
            assign age_hit   = (state_reg == AGE) && (idx_reg == IDX_W'(gi))
                               && (life_reg[gi] != 4'd0);
            assign shift_hit = (state_reg == SHIFT) && (mode_reg == MODE_PLAY);

            if (gi == 0) begin : g_head
                // Head entry: aged in place, then replaced by the new particle.
                always_ff @(posedge clk) begin
                    if (rst || clear) begin
                        x_reg[gi]    <= '0;
                        y_reg[gi]    <= '0;
                        life_reg[gi] <= '0;
                    end else if (age_hit) begin
                        if (x_reg[gi] < DRIFT_X) begin
                            life_reg[gi] <= 4'd0;
                        end else begin
                            x_reg[gi] <= x_reg[gi] - DRIFT_X;
                            if (decay_now_reg) begin
                                life_reg[gi] <= life_reg[gi] - 4'd1;
                            end
                        end
                    end else if (shift_hit) begin
                        x_reg[gi]    <= NEW_X;
                        y_reg[gi]    <= new_y;
                        life_reg[gi] <= NEW_LIFE;
                    end
                end
            end else begin : g_tail
                // Tail entry: aged in place, then takes its younger neighbour.
                always_ff @(posedge clk) begin
                    if (rst || clear) begin
                        x_reg[gi]    <= '0;
                        y_reg[gi]    <= '0;
                        life_reg[gi] <= '0;
                    end else if (age_hit) begin
                        if (x_reg[gi] < DRIFT_X) begin
                            life_reg[gi] <= 4'd0;
                        end else begin
                            x_reg[gi] <= x_reg[gi] - DRIFT_X;
                            if (decay_now_reg) begin
                                life_reg[gi] <= life_reg[gi] - 4'd1;
                            end
                        end
                    end else if (shift_hit) begin
                        x_reg[gi]    <= x_reg[gi-1];
                        y_reg[gi]    <= y_reg[gi-1];
                        life_reg[gi] <= life_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_trail_scheduler.sv
// Directed bench for trail_scheduler: reset, pause, insert, shift/decay,
// fade-out, tick-while-busy, start-mode abort and reset priority.
module tb_trail_scheduler;

    localparam int TRAIL_LEN = 41;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       frame_tick;
    logic [1:0]                 gamemode;
    logic [8:0]                 player_y;
    logic [TRAIL_LEN-1:0][9:0]  trail_x;
    logic [TRAIL_LEN-1:0][8:0]  trail_y;
    logic [TRAIL_LEN-1:0][3:0]  trail_life;
    logic                       busy;

    int checks = 0;
    int errors = 0;
    int bc;

    trail_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .gamemode   (gamemode),
        .player_y   (player_y),
        .trail_x    (trail_x),
        .trail_y    (trail_y),
        .trail_life (trail_life),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-18s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int live_count();
        int n = 0;
        for (int i = 0; i < TRAIL_LEN; i++) if (trail_life[i] != 4'd0) n++;
        return n;
    endfunction

    function automatic int any_nonzero();
        return ((|trail_x) || (|trail_y) || (|trail_life)) ? 1 : 0;
    endfunction

    task automatic check_entry(input string tag, input int i, input int x, input int y, input int l);
        check({tag, "_x"},    int'(trail_x[i]),    x);
        check({tag, "_y"},    int'(trail_y[i]),    y);
        check({tag, "_life"}, int'(trail_life[i]), l);
    endtask

    // Pulse frame_tick for one cycle, then count cycles with busy high.
    task automatic do_tick(output int cycles);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; gamemode = 2'b01; player_y = 9'd100;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset state, then pause tick ignored
        check("rst_busy", int'(busy), 0);
        check("rst_arrays", any_nonzero(), 0);
        gamemode = 2'b10;
        do_tick(bc);
        check("pause_busy_cyc", bc, 0);
        check("pause_arrays", any_nonzero(), 0);

        // 2: single play tick
        gamemode = 2'b01;
        do_tick(bc);
        check("t2_busy_cyc", bc, 42);
        check_entry("t2_e0", 0, 160, 120, 10);
        check("t2_live", live_count(), 1);

        // 3: four ticks, decay on the fourth
        do_reset();
        repeat (4) do_tick(bc);
        check_entry("t3_e0", 0, 160, 120, 10);
        check_entry("t3_e1", 1, 158, 120, 9);
        check_entry("t3_e2", 2, 156, 120, 9);
        check_entry("t3_e3", 3, 154, 120, 9);
        check("t3_live", live_count(), 4);

        // 4: game over fade-out
        gamemode = 2'b11;
        do_tick(bc);
        check_entry("t4a_e0", 0, 158, 120, 10);
        check("t4a_e4_life", int'(trail_life[4]), 0);
        check("t4a_live", live_count(), 4);
        repeat (39) do_tick(bc);
        check("t4_live", live_count(), 0);
        check("t4_e0_x", int'(trail_x[0]), 80);
        check("t4_e1_x", int'(trail_x[1]), 86);
        check("t4_e3_x", int'(trail_x[3]), 82);

        // 5: tick while busy is ignored, decay phase untouched
        do_reset();
        gamemode = 2'b01;
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            frame_tick = (bc == 10);
            @(negedge clk);
        end
        frame_tick = 1'b0;
        check("t5_busy_cyc", bc, 42);
        repeat (3) @(negedge clk);
        check("t5_idle_busy", int'(busy), 0);
        check_entry("t5_e0", 0, 160, 120, 10);
        check("t5_live", live_count(), 1);
        repeat (3) do_tick(bc);
        check_entry("t5_e1", 1, 158, 120, 9);

        // 6: start mode aborts a sweep at AGE idx 20
        do_reset();
        repeat (2) do_tick(bc);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_busy_pre", int'(busy), 1);
        gamemode = 2'b00;
        @(negedge clk);
        check("t6_busy_abort", int'(busy), 0);
        check("t6_arrays", any_nonzero(), 0);
        repeat (2) @(negedge clk);
        gamemode = 2'b01;
        do_tick(bc);
        check("t6_busy_cyc", bc, 42);
        check_entry("t6_e0", 0, 160, 120, 10);
        check("t6_live", live_count(), 1);
        do_tick(bc);
        check("t6_e1_life", int'(trail_life[1]), 10);

        // 7: reset outranks frame_tick in the same cycle
        @(negedge clk) begin rst = 1'b1; frame_tick = 1'b1; end
        @(negedge clk) begin rst = 1'b0; frame_tick = 1'b0; end
        check("t7_busy", int'(busy), 0);
        check("t7_arrays", any_nonzero(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
